// File: rtl/sc_ormask_splitter.sv
// Splits a mask word into its one-hot components. They are emitted lowest bit first
// over a valid/ready handshake. All outputs are registered.
module sc_ormask_splitter #(
    parameter int NUMBER_DATAWIDTH  = 8,
    parameter int NUMBER_INDEXWIDTH = $clog2(NUMBER_DATAWIDTH)
) (
    input  logic                         SC_ORSPLIT_CLOCK_50,
    input  logic                         SC_ORSPLIT_RESET_InHigh,
    input  logic                         SC_ORSPLIT_load_In,
    input  logic [NUMBER_DATAWIDTH-1:0]  SC_ORSPLIT_data_In,
    input  logic                         SC_ORSPLIT_ready_In,
    output logic [NUMBER_DATAWIDTH-1:0]  SC_ORSPLIT_onehot_Out,
    output logic [NUMBER_INDEXWIDTH-1:0] SC_ORSPLIT_index_Out,
    output logic                         SC_ORSPLIT_valid_Out,
    output logic                         SC_ORSPLIT_last_Out,
    output logic                         SC_ORSPLIT_busy_Out,
    output logic                         SC_ORSPLIT_done_Out
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [NUMBER_DATAWIDTH-1:0] LP_ONE = NUMBER_DATAWIDTH'(1);

    logic [1:0]                   r_state, w_state_n;
    logic [NUMBER_DATAWIDTH-1:0]  r_mask, w_mask_n, w_low_n, r_onehot;
    logic [NUMBER_INDEXWIDTH-1:0] w_idx_n, r_index;
    logic                         r_last, r_valid, r_busy, r_done;
    logic                         w_hs, w_last_n, w_emit_n;

    always_comb begin
        w_state_n = r_state;
        w_mask_n  = r_mask;
        w_hs      = r_valid & SC_ORSPLIT_ready_In;
        case (r_state)
            ST_IDLE: if (SC_ORSPLIT_load_In) begin
                w_mask_n  = SC_ORSPLIT_data_In;
                w_state_n = (SC_ORSPLIT_data_In != '0) ? ST_EMIT : ST_DONE;
            end
            ST_EMIT: if (w_hs) begin
                w_mask_n = r_mask & ~r_onehot;
                if (r_last) w_state_n = ST_DONE;
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase

        // The output registers are loaded from the next mask. A stall re-registers the same component.
        w_low_n  = w_mask_n & (~w_mask_n + LP_ONE);
        w_last_n = (w_mask_n != '0) && ((w_mask_n & (w_mask_n - LP_ONE)) == '0);
        w_idx_n  = '0;
        for (int i = NUMBER_DATAWIDTH - 1; i >= 0; i--)
            if (w_mask_n[i]) w_idx_n = NUMBER_INDEXWIDTH'(i);
        w_emit_n = (w_state_n == ST_EMIT);
    end

    always_ff @(posedge SC_ORSPLIT_CLOCK_50 or posedge SC_ORSPLIT_RESET_InHigh) begin
        if (SC_ORSPLIT_RESET_InHigh) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_onehot <= '0;
            r_index  <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_mask   <= w_mask_n;
            r_onehot <= w_emit_n ? w_low_n : '0;
            r_index  <= w_emit_n ? w_idx_n : '0;
            r_last   <= w_emit_n & w_last_n;
            r_valid  <= w_emit_n;
            r_busy   <= (w_state_n != ST_IDLE);
            r_done   <= (w_state_n == ST_DONE);
        end
    end

    assign SC_ORSPLIT_onehot_Out = r_onehot;
    assign SC_ORSPLIT_index_Out  = r_index;
    assign SC_ORSPLIT_valid_Out  = r_valid;
    assign SC_ORSPLIT_last_Out   = r_last;
    assign SC_ORSPLIT_busy_Out   = r_busy;
    assign SC_ORSPLIT_done_Out   = r_done;
endmodule

// File: tb/tb_sc_ormask_splitter.sv
// Randomized and directed bench for sc_ormask_splitter.
// A queue-based reference model predicts every output on every cycle.
module tb_sc_ormask_splitter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic       ready = 1'b0;
    logic [7:0] onehot;
    logic [2:0] index;
    logic       valid, last, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 emitting, 2 done; q holds pending bit indices.
    int         mode = 0;
    int         q[$];
    logic [7:0] m_loaded = '0;
    logic [7:0] sb_or = '0;
    int         sb_cnt = 0;

    sc_ormask_splitter #(.NUMBER_DATAWIDTH(8)) dut (
        .SC_ORSPLIT_CLOCK_50     (clk),
        .SC_ORSPLIT_RESET_InHigh (rst),
        .SC_ORSPLIT_load_In      (load),
        .SC_ORSPLIT_data_In      (data),
        .SC_ORSPLIT_ready_In     (ready),
        .SC_ORSPLIT_onehot_Out   (onehot),
        .SC_ORSPLIT_index_Out    (index),
        .SC_ORSPLIT_valid_Out    (valid),
        .SC_ORSPLIT_last_Out     (last),
        .SC_ORSPLIT_busy_Out     (busy),
        .SC_ORSPLIT_done_Out     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_oh, e_idx;
        e_oh  = 0;
        e_idx = 0;
        if (mode == 1 && q.size() > 0) begin
            e_oh  = 32'd1 << q[0];
            e_idx = q[0];
        end
        chk("valid", {31'd0, valid}, {31'd0, mode == 1});
        chk("busy",  {31'd0, busy},  {31'd0, mode != 0});
        chk("done",  {31'd0, done},  {31'd0, mode == 2});
        chk("last",  {31'd0, last},  {31'd0, mode == 1 && q.size() == 1});
        chk("onehot", {24'd0, onehot}, e_oh);
        chk("index",  {29'd0, index},  e_idx);
        if (done) begin
            chk("sb_or",  {24'd0, sb_or}, {24'd0, m_loaded});
            chk("sb_cnt", sb_cnt, $countones(m_loaded));
            sb_or  = '0;
            sb_cnt = 0;
        end
    endtask

    // One clock cycle: drive, record the DUT handshake, step the model, then check at negedge.
    task automatic cyc(input logic l, input logic [7:0] d, input logic r);
        load  = l;
        data  = d;
        ready = r;
        #1;
        if (valid && r) begin
            sb_or  = sb_or | onehot;
            sb_cnt = sb_cnt + 1;
        end
        @(posedge clk);
        case (mode)
            0: if (l) begin
                m_loaded = d;
                q.delete();
                for (int i = 0; i < 8; i++) if (d[i]) q.push_back(i);
                mode = (q.size() > 0) ? 1 : 2;
            end
            1: if (r) begin
                void'(q.pop_front());
                if (q.size() == 0) mode = 2;
            end
            default: mode = 0;
        endcase
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid",  {31'd0, valid}, 32'd0);
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_last",   {31'd0, last},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_onehot", {24'd0, onehot}, 32'd0);
        mode = 0;
        q.delete();
        sb_or  = '0;
        sb_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // 0xA6 with ready held high.
        cyc(1, 8'hA6, 1);
        repeat (6) cyc(0, 8'h00, 1);

        // Empty mask goes straight to a done pulse.
        cyc(1, 8'h00, 1);
        repeat (2) cyc(0, 8'h00, 1);

        // 0x11 with ready toggling 0,0,1,0,1.
        cyc(1, 8'h11, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        repeat (2) cyc(0, 8'h00, 1);

        // 0xFF while load stays asserted with 0x01, including the done cycle.
        cyc(1, 8'hFF, 1);
        repeat (9) cyc(1, 8'h01, 1);
        repeat (2) cyc(0, 8'h00, 1);

        // Reset during emission, then an MSB-only load.
        cyc(1, 8'hF0, 1);
        cyc(0, 8'h00, 1);
        async_reset();
        cyc(1, 8'h80, 1);
        repeat (3) cyc(0, 8'h00, 1);

        // Random masks, loads and ready.
        for (int n = 0; n < 400; n++) begin
            rd = 8'($urandom);
            if ($urandom_range(7) == 0) rd = 8'h00;
            cyc(($urandom_range(3) == 0), rd, ($urandom_range(1) == 1));
        end
        repeat (12) cyc(0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
